clkdiv_tick_sched: RTL
======================

// Module: clkdiv_tick_sched
// PURPOSE
//   Turns the free-running clkdiv[31:0] divider bus into per-channel single-cycle clock-enable strobes.
//   Each channel has a selectable tap bit and an edge-count reload value, both set through a write-only config port.
//   Consumers in the VGA/2048 design (animation, key scan, 7-seg scan) use these strobes instead of raw divided clocks.
//   A global run/pause/step controller freezes or single-steps all channels together for debug.
// PARAMETERS
//   NCH         4    number of tick channels (2..8)
//   CW          8    width of per-channel reload/count register
//   DEFAULT_TAP 16   tap index loaded into every channel at reset
// PORTS
//   clk        in   1           system clock; clkdiv is generated from this clock
//   rst        in   1           asynchronous, active-low reset
//   clkdiv     in   32          free-running divider bus
//   cfg_we     in   1           config write strobe (one cycle)
//   cfg_ch     in   $clog2(NCH) channel to configure
//   cfg_tap    in   5           tap index into clkdiv
//   cfg_reload in   CW          edges per tick minus 1
//   cfg_en     in   1           channel enable
//   run        in   1           level: 1 = run, 0 = pause
//   step       in   1           single-step request; acts on its rising edge
//   tick       out  NCH         registered single-cycle strobe, one bit per channel
//   ch_en      out  NCH         current enable bit of each channel
//   paused     out  1           1 when the controller is not in RUN
// BEHAVIOUR
//   Reset (rst=0, async): tap_i=DEFAULT_TAP, reload_i=0, en_i=0, cnt_i=0, prev_i=0, step_q=0;
//     tick=0, ch_en=0, state=PAUSE, paused=1.
//   Per-channel edge detect: bit_i=clkdiv[tap_i]; rise_i = bit_i & ~prev_i.
//     prev_i<=bit_i every cycle in every state, so no stale edge is seen on resume.
//   FSM states (2-bit, registered):
//     RUN:   run=0 -> PAUSE.
//     PAUSE: run=1 -> RUN; this takes priority over step.
//            otherwise step & ~step_q -> STEP.
//     STEP:  lasts exactly 1 cycle; then run ? RUN : PAUSE.
//     step_q <= step every cycle.
//   Counting, RUN only, channel with en_i=1 and rise_i=1:
//     cnt_i==0 -> tick_i<=1 and cnt_i<=reload_i; otherwise cnt_i<=cnt_i-1.
//     Tick period = (reload_i+1) rising edges of the tap; reload=0 gives a tick on every edge.
//   STEP: every enabled channel gets tick_i<=1 and cnt_i<=reload_i, regardless of edges.
//   PAUSE: cnt_i holds and tick=0.
//   tick is registered: a tap bit that rises in the clkdiv sample of cycle n gives a tick high in cycle n+1, for 1 cycle only.
//   Config write (cfg_we=1, cfg_ch<NCH):
//     next edge: tap, reload and en of cfg_ch are loaded; cnt<=cfg_reload; prev<=clkdiv[cfg_tap]; tick of that channel <=0.
//     The write overrides count/step for that channel in that cycle; other channels are unaffected.
//     cfg_ch>=NCH: write ignored.
//   Disabled channel (en_i=0): tick_i stays 0 and cnt_i holds.
//   ch_en = en register vector. paused = (state!=RUN).
//   Tap 0 (toggles every clk) -> rise every 2 cycles; this is legal.
//   cnt wraps only by reload, never below 0.
//   Reset asserted mid-tick clears tick at once (async).
// TESTING
//   1. Reset, run=1, write ch0 tap=2, reload=0, en=1 -> tick[0] one cycle wide every 8 clk; tick[3:1]=0.
//   2. Write ch1 tap=3, reload=2, en=1 -> tick[1] every 48 clk, i.e. every 3rd rise of clkdiv[3], 1-cycle wide.
//   3. run 1->0 mid-count -> paused=1 next cycle, no ticks.
//      Then a step pulse -> exactly one tick on each enabled channel 2 cycles later.
//      Then run=1 -> counting resumes from reload, with no extra tick from a stale edge.
//   4. run=0 and step rising in the same cycle run goes to 1 -> state RUN, no STEP tick.
//   5. Config write to ch0 in the same cycle as its counted edge -> no tick that cycle; cnt=cfg_reload;
//      cfg_ch=NCH write leaves all channels unchanged.
//   6. rst pulled low while tick[0]=1 -> tick=0, ch_en=0, paused=1 at once;
//      after release nothing ticks until channels are reconfigured.

Source files
------------

// File: rtl/clkdiv_tick_sched.sv
// clkdiv_tick_sched: per-channel single-cycle clock-enable strobes derived
// from taps of a free-running divider bus, with a global run/pause/step
// controller that freezes or single-steps every channel together.
module clkdiv_tick_sched #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned CW          = 8,
    parameter int unsigned DEFAULT_TAP = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            clkdiv,
    input  logic                   cfg_we,
    input  logic [$clog2(NCH)-1:0] cfg_ch,
    input  logic [4:0]             cfg_tap,
    input  logic [CW-1:0]          cfg_reload,
    input  logic                   cfg_en,
    input  logic                   run,
    input  logic                   step,
    output logic [NCH-1:0]         tick,
    output logic [NCH-1:0]         ch_en,
    output logic                   paused
);

    localparam int unsigned CHW   = $clog2(NCH);
    localparam logic [CHW:0] NCH_L = (CHW+1)'(NCH);
    localparam logic [4:0] TAP_RST = 5'(DEFAULT_TAP);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_STEP  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic                       step_q, step_d;
    logic [NCH-1:0][4:0]        tap_q, tap_d;
    logic [NCH-1:0][CW-1:0]     reload_q, reload_d;
    logic [NCH-1:0][CW-1:0]     cnt_q, cnt_d;
    logic [NCH-1:0]             en_q, en_d;
    logic [NCH-1:0]             prev_q, prev_d;
    logic [NCH-1:0]             tick_q, tick_d;
    logic [NCH-1:0]             bit_now, rise;
    logic                       cfg_valid;

    // Controller next state: run has priority over a step edge while paused.
    always_comb begin
        state_d = state_q;
        step_d  = step;
        case (state_q)
            ST_RUN:   if (!run) state_d = ST_PAUSE;
            ST_PAUSE: begin
                if (run)                  state_d = ST_RUN;
                else if (step && !step_q) state_d = ST_STEP;
            end
            ST_STEP:  state_d = run ? ST_RUN : ST_PAUSE;
            default:  state_d = ST_PAUSE;
        endcase
    end

    // Per-channel edge detect, counting, step strobes and config override.
    always_comb begin
        tap_d     = tap_q;
        reload_d  = reload_q;
        cnt_d     = cnt_q;
        en_d      = en_q;
        prev_d    = '0;
        tick_d    = '0;
        bit_now   = '0;
        rise      = '0;
        cfg_valid = cfg_we && ({1'b0, cfg_ch} < NCH_L);
        for (int unsigned i = 0; i < NCH; i++) begin
            bit_now[i] = clkdiv[tap_q[i]];
            rise[i]    = bit_now[i] & ~prev_q[i];
            // prev tracks the tap in every state so a resume never sees a stale edge
            prev_d[i]  = bit_now[i];
            if (en_q[i]) begin
                if (state_q == ST_RUN && rise[i]) begin
                    if (cnt_q[i] == '0) begin
                        tick_d[i] = 1'b1;
                        cnt_d[i]  = reload_q[i];
                    end else begin
                        cnt_d[i]  = cnt_q[i] - CW'(1);
                    end
                end else if (state_q == ST_STEP) begin
                    tick_d[i] = 1'b1;
                    cnt_d[i]  = reload_q[i];
                end
            end
            if (cfg_valid && (cfg_ch == CHW'(i))) begin
                tap_d[i]    = cfg_tap;
                reload_d[i] = cfg_reload;
                en_d[i]     = cfg_en;
                cnt_d[i]    = cfg_reload;
                prev_d[i]   = clkdiv[cfg_tap];
                tick_d[i]   = 1'b0;
            end
        end
    end

    // State and channel registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_PAUSE;
            step_q   <= 1'b0;
            tap_q    <= {NCH{TAP_RST}};
            reload_q <= '0;
            cnt_q    <= '0;
            en_q     <= '0;
            prev_q   <= '0;
            tick_q   <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            tap_q    <= tap_d;
            reload_q <= reload_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            prev_q   <= prev_d;
            tick_q   <= tick_d;
        end
    end

    assign tick   = tick_q;
    assign ch_en  = en_q;
    assign paused = (state_q != ST_RUN);

endmodule
